id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register for the RV32I core. It sits directly upstream of the ALU.
- Captures decoded operands and control each cycle, honouring stall and flush.
- Applies EX/MEM and MEM/WB forwarding to the registered operands, then presents op1, op2 and ALUctrl to the ALU.
- Also carries store data and writeback control down the pipe.

Parameters:
- DATA_WIDTH, 32, operand, immediate and PC width.
- REG_ADDR_WIDTH, 5, register-file address width.

Ports:
- clk  input  1  core clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  hold all registered state this cycle.
- flush  input  1  replace the captured instruction with a bubble.
- id_valid  input  1  decode slot holds a real instruction.
- id_rd1  input  DATA_WIDTH  register-file read data rs1.
- id_rd2  input  DATA_WIDTH  register-file read data rs2.
- id_imm  input  DATA_WIDTH  sign-extended immediate.
- id_pc  input  DATA_WIDTH  instruction PC.
- id_rs1  input  REG_ADDR_WIDTH  source register 1 address.
- id_rs2  input  REG_ADDR_WIDTH  source register 2 address.
- id_rd  input  REG_ADDR_WIDTH  destination register address.
- id_aluctrl  input  3  ALU operation: 000 add, 001 sub, 010 pass op2.
- id_alusrc  input  1  op2 source: 1 immediate, 0 rs2.
- id_regwrite  input  1  writes the register file.
- id_memwrite  input  1  store.
- id_memread  input  1  load.
- id_branch  input  1  conditional branch, resolved on ALU zero.
- exm_regwrite  input  1  EX/MEM stage writes a register.
- exm_rd  input  REG_ADDR_WIDTH  EX/MEM destination register.
- exm_result  input  DATA_WIDTH  EX/MEM ALU result.
- wb_regwrite  input  1  MEM/WB stage writes a register.
- wb_rd  input  REG_ADDR_WIDTH  MEM/WB destination register.
- wb_result  input  DATA_WIDTH  MEM/WB writeback value.
- op1  output  DATA_WIDTH  ALU operand 1 (forwarded rs1).
- op2  output  DATA_WIDTH  ALU operand 2 (immediate or forwarded rs2).
- ALUctrl  output  3  registered ALU operation.
- ex_store_data  output  DATA_WIDTH  forwarded rs2 for stores.
- ex_pc  output  DATA_WIDTH  registered PC.
- ex_rd  output  REG_ADDR_WIDTH  registered destination register.
- ex_valid  output  1  registered valid.
- ex_regwrite  output  1  registered control, gated by valid.
- ex_memwrite  output  1  registered control, gated by valid.
- ex_memread  output  1  registered control, gated by valid.
- ex_branch  output  1  registered control, gated by valid.
- stall_req  output  1  load-use hazard request (see Optional Feature).

Behaviour:
- Reset (rst_n low, asynchronous):
  - All registers cleared to 0; ex_valid=0; all control outputs 0.
  - ALUctrl=000; op1, op2 and ex_store_data = 0, since forwarding cannot match a zero rd.
- Capture priority per rising edge:
  - flush: load a bubble. valid=0, regwrite, memwrite, memread and branch =0, rd=0, ALUctrl=000. Data fields may load.
  - else stall: hold every register.
  - else: load all id_* fields.
  - flush wins over stall when both are high.
- Latency: one cycle from the id_* inputs to the registered fields. Forwarding and op muxing are combinational on the registered values in the same cycle.
- Control outputs are the registered control ANDed with ex_valid. Register-file and memory side effects are therefore impossible from a bubble.
- rs1 forwarding, applied in this order:
  - If exm_regwrite && exm_rd!=0 && exm_rd==rs1_q, use exm_result.
  - Else if wb_regwrite && wb_rd!=0 && wb_rd==rs1_q, use wb_result.
  - Else use rd1_q.
- rs2 forwarding: same rules against rs2_q, giving fwd2.
- Operand outputs:
  - op1 = fwd1.
  - op2 = alusrc_q ? imm_q : fwd2.
  - ex_store_data = fwd2 always.
- Register x0 is never a forwarding target. A zero rd never matches, even when regwrite=1.
- During a stall, forwarding keeps tracking the live exm_* and wb_* inputs, so the operands may change while the registers are held.
- An asynchronous reset mid-stall overrides everything; the first post-reset cycle always shows a bubble.

Optional Feature:
- Macro: LOAD_USE_DETECT_EN.
- Defined: stall_req = ex_valid && ex_memread_q && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2). The result is combinational. The hazard unit drives stall to the fetch/decode stages and flush to this stage for one cycle, inserting a single bubble.
- Not defined: stall_req is tied to 0; load-use hazards are resolved by software or the external hazard unit.

Test Plan:
- Reset: assert rst_n=0 mid-cycle with id_valid=1 and id_rd=5 -> ex_valid=0, ex_regwrite=0 and op1=0 immediately. The first edge after release captures the id_* values.
- Plain capture: id_rd1=7, id_imm=3, alusrc=1, aluctrl=000 -> next cycle op1=7, op2=3, ALUctrl=000.
- Forwarding priority: rs1_q=4, exm(rd=4, result=0x11, we=1) and wb(rd=4, result=0x22, we=1) -> op1=0x11. With exm_regwrite=0 -> op1=0x22.
- x0 guard: rs2_q=0, exm_rd=0, exm_regwrite=1, exm_result=0xFF, rd2_q=0 -> ex_store_data=0.
- Stall/flush: stall=1 for 2 cycles with changing id_* -> outputs hold. stall=1 and flush=1 together -> ex_valid=0 and ex_memwrite=0 next cycle.
- Load-use (LOAD_USE_DETECT_EN): ex_memread=1, ex_rd=6, id_rs2=6 -> stall_req=1. Same case with ex_rd=0 -> stall_req=0. Macro undefined -> stall_req=0 in both cases.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// ID/EX stage interface: groups decode inputs, forwarding sources, hazard
// controls and the ALU-facing outputs of the decode-to-execute register.
// master: decode/hazard/forwarding side that drives the stage.
// slave : the id_ex_stage itself.
interface id_ex_stage_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
);
  // Hazard control
  logic                      stall;
  logic                      flush;

  // Decoded instruction
  logic                      id_valid;
  logic [DATA_WIDTH-1:0]     id_rd1;
  logic [DATA_WIDTH-1:0]     id_rd2;
  logic [DATA_WIDTH-1:0]     id_imm;
  logic [DATA_WIDTH-1:0]     id_pc;
  logic [REG_ADDR_WIDTH-1:0] id_rs1;
  logic [REG_ADDR_WIDTH-1:0] id_rs2;
  logic [REG_ADDR_WIDTH-1:0] id_rd;
  logic [2:0]                id_aluctrl;
  logic                      id_alusrc;
  logic                      id_regwrite;
  logic                      id_memwrite;
  logic                      id_memread;
  logic                      id_branch;

  // Forwarding sources
  logic                      exm_regwrite;
  logic [REG_ADDR_WIDTH-1:0] exm_rd;
  logic [DATA_WIDTH-1:0]     exm_result;
  logic                      wb_regwrite;
  logic [REG_ADDR_WIDTH-1:0] wb_rd;
  logic [DATA_WIDTH-1:0]     wb_result;

  // Execute-side outputs
  logic [DATA_WIDTH-1:0]     op1;
  logic [DATA_WIDTH-1:0]     op2;
  logic [2:0]                ALUctrl;
  logic [DATA_WIDTH-1:0]     ex_store_data;
  logic [DATA_WIDTH-1:0]     ex_pc;
  logic [REG_ADDR_WIDTH-1:0] ex_rd;
  logic                      ex_valid;
  logic                      ex_regwrite;
  logic                      ex_memwrite;
  logic                      ex_memread;
  logic                      ex_branch;
  logic                      stall_req;

  modport master (
    output stall, flush,
    output id_valid, id_rd1, id_rd2, id_imm, id_pc, id_rs1, id_rs2, id_rd,
    output id_aluctrl, id_alusrc, id_regwrite, id_memwrite, id_memread, id_branch,
    output exm_regwrite, exm_rd, exm_result, wb_regwrite, wb_rd, wb_result,
    input  op1, op2, ALUctrl, ex_store_data, ex_pc, ex_rd, ex_valid,
    input  ex_regwrite, ex_memwrite, ex_memread, ex_branch, stall_req
  );

  modport slave (
    input  stall, flush,
    input  id_valid, id_rd1, id_rd2, id_imm, id_pc, id_rs1, id_rs2, id_rd,
    input  id_aluctrl, id_alusrc, id_regwrite, id_memwrite, id_memread, id_branch,
    input  exm_regwrite, exm_rd, exm_result, wb_regwrite, wb_rd, wb_result,
    output op1, op2, ALUctrl, ex_store_data, ex_pc, ex_rd, ex_valid,
    output ex_regwrite, ex_memwrite, ex_memread, ex_branch, stall_req
  );
endinterface

// File: rtl/id_ex_stage.sv
// RV32I decode-to-execute pipeline register. Captures decoded operands and
// control with flush > stall > load priority, forwards EX/MEM and MEM/WB
// results onto the registered operands, and presents op1/op2/ALUctrl to the ALU.
// Optional load-use detection is enabled by defining LOAD_USE_DETECT_EN;
// otherwise stall_req is tied low.
module id_ex_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  id_ex_stage_if.slave bus
);

  // Control registers
  logic                      r_valid;
  logic                      r_regwrite;
  logic                      r_memwrite;
  logic                      r_memread;
  logic                      r_branch;
  logic [REG_ADDR_WIDTH-1:0] r_rd;
  logic [2:0]                r_aluctrl;

  // Data registers
  logic [DATA_WIDTH-1:0]     r_rd1;
  logic [DATA_WIDTH-1:0]     r_rd2;
  logic [DATA_WIDTH-1:0]     r_imm;
  logic [DATA_WIDTH-1:0]     r_pc;
  logic [REG_ADDR_WIDTH-1:0] r_rs1;
  logic [REG_ADDR_WIDTH-1:0] r_rs2;
  logic                      r_alusrc;

  // Forwarding
  logic                      w_exm_hit1;
  logic                      w_wb_hit1;
  logic                      w_exm_hit2;
  logic                      w_wb_hit2;
  logic [DATA_WIDTH-1:0]     w_fwd1;
  logic [DATA_WIDTH-1:0]     w_fwd2;
  logic                      w_load_data;
  logic                      w_stall_req;

  // Data fields load on a flush too: the bubble is made harmless by the
  // cleared control path, so the data path only needs a single enable.
  assign w_load_data = bus.flush || !bus.stall;

  // Control path: flush inserts a bubble, stall holds, otherwise capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_branch   <= 1'b0;
      r_rd       <= '0;
      r_aluctrl  <= 3'b000;
    end else if (bus.flush) begin
      r_valid    <= 1'b0;
      r_regwrite <= 1'b0;
      r_memwrite <= 1'b0;
      r_memread  <= 1'b0;
      r_branch   <= 1'b0;
      r_rd       <= '0;
      r_aluctrl  <= 3'b000;
    end else if (!bus.stall) begin
      r_valid    <= bus.id_valid;
      r_regwrite <= bus.id_regwrite;
      r_memwrite <= bus.id_memwrite;
      r_memread  <= bus.id_memread;
      r_branch   <= bus.id_branch;
      r_rd       <= bus.id_rd;
      r_aluctrl  <= bus.id_aluctrl;
    end
  end

  // Data path: operands, immediate, PC and source addresses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd1    <= '0;
      r_rd2    <= '0;
      r_imm    <= '0;
      r_pc     <= '0;
      r_rs1    <= '0;
      r_rs2    <= '0;
      r_alusrc <= 1'b0;
    end else if (w_load_data) begin
      r_rd1    <= bus.id_rd1;
      r_rd2    <= bus.id_rd2;
      r_imm    <= bus.id_imm;
      r_pc     <= bus.id_pc;
      r_rs1    <= bus.id_rs1;
      r_rs2    <= bus.id_rs2;
      r_alusrc <= bus.id_alusrc;
    end
  end

  // Hit detection against the live EX/MEM and MEM/WB writers; x0 never matches.
  always_comb begin
    w_exm_hit1 = bus.exm_regwrite && (bus.exm_rd != '0) && (bus.exm_rd == r_rs1);
    w_wb_hit1  = bus.wb_regwrite  && (bus.wb_rd  != '0) && (bus.wb_rd  == r_rs1);
    w_exm_hit2 = bus.exm_regwrite && (bus.exm_rd != '0) && (bus.exm_rd == r_rs2);
    w_wb_hit2  = bus.wb_regwrite  && (bus.wb_rd  != '0) && (bus.wb_rd  == r_rs2);
  end

  // rs1 operand: the younger EX/MEM result takes priority over MEM/WB.
  always_comb begin
    w_fwd1 = r_rd1;
    if (w_exm_hit1) begin
      w_fwd1 = bus.exm_result;
    end else if (w_wb_hit1) begin
      w_fwd1 = bus.wb_result;
    end
  end

  // rs2 operand: same priority as rs1.
  always_comb begin
    w_fwd2 = r_rd2;
    if (w_exm_hit2) begin
      w_fwd2 = bus.exm_result;
    end else if (w_wb_hit2) begin
      w_fwd2 = bus.wb_result;
    end
  end

`ifdef LOAD_USE_DETECT_EN
  // Load in EX whose destination is read by the instruction now in decode.
  always_comb begin
    w_stall_req = r_valid && r_memread && (r_rd != '0) &&
                  ((r_rd == bus.id_rs1) || (r_rd == bus.id_rs2));
  end
`else
  // Load-use hazards are handled outside this stage.
  always_comb begin
    w_stall_req = 1'b0;
  end
`endif

  assign bus.op1           = w_fwd1;
  assign bus.op2           = r_alusrc ? r_imm : w_fwd2;
  assign bus.ALUctrl       = r_aluctrl;
  assign bus.ex_store_data = w_fwd2;
  assign bus.ex_pc         = r_pc;
  assign bus.ex_rd         = r_rd;
  assign bus.ex_valid      = r_valid;
  assign bus.ex_regwrite   = r_regwrite && r_valid;
  assign bus.ex_memwrite   = r_memwrite && r_valid;
  assign bus.ex_memread    = r_memread  && r_valid;
  assign bus.ex_branch     = r_branch   && r_valid;
  assign bus.stall_req     = w_stall_req;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases for reset, capture,
// forwarding priority, x0 guard, stall/flush and load-use, followed by
// randomized traffic compared against an instruction-level reference model.
module tb_id_ex_stage;
  localparam int DW = 32;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  id_ex_stage_if #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) bus ();

  id_ex_stage #(.DATA_WIDTH(DW), .REG_ADDR_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: the instruction currently sitting in EX.
  typedef struct {
    bit            valid;
    bit            data_known;
    logic [DW-1:0] rd1, rd2, imm, pc;
    logic [AW-1:0] rs1, rs2, rd;
    logic [2:0]    aluctrl;
    bit            alusrc, regwrite, memwrite, memread, branch;
  } instr_t;

  instr_t m;

  task automatic check_eq(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m = '{valid: 1'b0, data_known: 1'b1, rd1: '0, rd2: '0, imm: '0, pc: '0,
          rs1: '0, rs2: '0, rd: '0, aluctrl: 3'b000, alusrc: 1'b0,
          regwrite: 1'b0, memwrite: 1'b0, memread: 1'b0, branch: 1'b0};
  endtask

  // Pipeline-register semantics at a rising edge.
  task automatic model_edge();
    if (bus.flush) begin
      m.valid = 1'b0; m.regwrite = 1'b0; m.memwrite = 1'b0; m.memread = 1'b0;
      m.branch = 1'b0; m.rd = '0; m.aluctrl = 3'b000;
      m.data_known = 1'b0;  // data fields of a bubble are don't-care
    end else if (!bus.stall) begin
      m.valid = bus.id_valid; m.regwrite = bus.id_regwrite; m.memwrite = bus.id_memwrite;
      m.memread = bus.id_memread; m.branch = bus.id_branch; m.rd = bus.id_rd;
      m.aluctrl = bus.id_aluctrl; m.rd1 = bus.id_rd1; m.rd2 = bus.id_rd2;
      m.imm = bus.id_imm; m.pc = bus.id_pc; m.rs1 = bus.id_rs1; m.rs2 = bus.id_rs2;
      m.alusrc = bus.id_alusrc; m.data_known = 1'b1;
    end
  endtask

  // Value an instruction should see for a source register, given the live writers.
  function automatic logic [DW-1:0] source_value(input logic [AW-1:0] rs, input logic [DW-1:0] regval);
    if (bus.exm_regwrite && bus.exm_rd != 0 && bus.exm_rd == rs) return bus.exm_result;
    if (bus.wb_regwrite && bus.wb_rd != 0 && bus.wb_rd == rs) return bus.wb_result;
    return regval;
  endfunction

  function automatic logic expected_stall_req();
`ifdef LOAD_USE_DETECT_EN
    return m.valid && m.memread && m.rd != 0 && (m.rd == bus.id_rs1 || m.rd == bus.id_rs2);
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_outputs(input string ph);
    logic [DW-1:0] s1, s2;
    s1 = source_value(m.rs1, m.rd1);
    s2 = source_value(m.rs2, m.rd2);
    check_eq({ph, "ex_valid"},    DW'(bus.ex_valid),    DW'(m.valid));
    check_eq({ph, "ex_regwrite"}, DW'(bus.ex_regwrite), DW'(m.valid & m.regwrite));
    check_eq({ph, "ex_memwrite"}, DW'(bus.ex_memwrite), DW'(m.valid & m.memwrite));
    check_eq({ph, "ex_memread"},  DW'(bus.ex_memread),  DW'(m.valid & m.memread));
    check_eq({ph, "ex_branch"},   DW'(bus.ex_branch),   DW'(m.valid & m.branch));
    check_eq({ph, "ALUctrl"},     DW'(bus.ALUctrl),     DW'(m.aluctrl));
    check_eq({ph, "ex_rd"},       DW'(bus.ex_rd),       DW'(m.rd));
    check_eq({ph, "stall_req"},   DW'(bus.stall_req),   DW'(expected_stall_req()));
    if (m.data_known) begin
      check_eq({ph, "op1"},           bus.op1,           s1);
      check_eq({ph, "op2"},           bus.op2,           m.alusrc ? m.imm : s2);
      check_eq({ph, "ex_store_data"}, bus.ex_store_data, s2);
      check_eq({ph, "ex_pc"},         bus.ex_pc,         m.pc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs("post_");
  endtask

  task automatic clear_inputs();
    bus.stall = 1'b0; bus.flush = 1'b0; bus.id_valid = 1'b0;
    bus.id_rd1 = '0; bus.id_rd2 = '0; bus.id_imm = '0; bus.id_pc = '0;
    bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rd = '0; bus.id_aluctrl = 3'b000;
    bus.id_alusrc = 1'b0; bus.id_regwrite = 1'b0; bus.id_memwrite = 1'b0;
    bus.id_memread = 1'b0; bus.id_branch = 1'b0;
    bus.exm_regwrite = 1'b0; bus.exm_rd = '0; bus.exm_result = '0;
    bus.wb_regwrite = 1'b0; bus.wb_rd = '0; bus.wb_result = '0;
  endtask

  task automatic random_fwd();
    bus.exm_regwrite = 1'($urandom_range(0, 1));
    bus.exm_rd       = AW'($urandom_range(0, 7));
    bus.exm_result   = $urandom;
    bus.wb_regwrite  = 1'($urandom_range(0, 1));
    bus.wb_rd        = AW'($urandom_range(0, 7));
    bus.wb_result    = $urandom;
  endtask

  task automatic random_inputs();
    bus.stall       = ($urandom_range(0, 3) == 0);
    bus.flush       = ($urandom_range(0, 7) == 0);
    bus.id_valid    = ($urandom_range(0, 3) != 0);
    bus.id_rd1      = $urandom;
    bus.id_rd2      = $urandom;
    bus.id_imm      = $urandom;
    bus.id_pc       = $urandom;
    bus.id_rs1      = AW'($urandom_range(0, 7));
    bus.id_rs2      = AW'($urandom_range(0, 7));
    bus.id_rd       = AW'($urandom_range(0, 7));
    bus.id_aluctrl  = 3'($urandom_range(0, 2));
    bus.id_alusrc   = 1'($urandom_range(0, 1));
    bus.id_regwrite = 1'($urandom_range(0, 1));
    bus.id_memwrite = 1'($urandom_range(0, 1));
    bus.id_memread  = 1'($urandom_range(0, 1));
    bus.id_branch   = 1'($urandom_range(0, 1));
    random_fwd();
  endtask

  initial begin
    logic exp_lu;
    clear_inputs();
    rst_n = 1'b0;
    model_reset();
    #12;
    check_outputs("reset_");
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted mid-cycle over a valid instruction
    bus.id_valid = 1'b1; bus.id_rd = 5'd5; bus.id_regwrite = 1'b1;
    tick();
    check_eq("cap_valid", DW'(bus.ex_valid), 32'd1);
    #3;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_eq("rst_ex_valid", DW'(bus.ex_valid), 32'd0);
    check_eq("rst_ex_regwrite", DW'(bus.ex_regwrite), 32'd0);
    check_eq("rst_op1", bus.op1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_eq("post_rst_ex_rd", DW'(bus.ex_rd), 32'd5);
    check_eq("post_rst_ex_valid", DW'(bus.ex_valid), 32'd1);

    // Plain capture
    clear_inputs();
    bus.id_valid = 1'b1; bus.id_rd1 = 32'd7; bus.id_imm = 32'd3;
    bus.id_alusrc = 1'b1; bus.id_aluctrl = 3'b000; bus.id_rs1 = 5'd1;
    tick();
    check_eq("plain_op1", bus.op1, 32'd7);
    check_eq("plain_op2", bus.op2, 32'd3);
    check_eq("plain_aluctrl", DW'(bus.ALUctrl), 32'd0);

    // Forwarding priority on rs1
    clear_inputs();
    bus.id_valid = 1'b1; bus.id_rs1 = 5'd4; bus.id_rd1 = 32'h99;
    tick();
    bus.exm_regwrite = 1'b1; bus.exm_rd = 5'd4; bus.exm_result = 32'h11;
    bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd4; bus.wb_result = 32'h22;
    #1;
    check_eq("fwd_exm_first", bus.op1, 32'h11);
    bus.exm_regwrite = 1'b0;
    #1;
    check_eq("fwd_wb", bus.op1, 32'h22);
    bus.wb_regwrite = 1'b0;
    #1;
    check_eq("fwd_none", bus.op1, 32'h99);

    // x0 never forwards
    clear_inputs();
    bus.id_valid = 1'b1; bus.id_rs2 = 5'd0; bus.id_rd2 = 32'd0; bus.id_alusrc = 1'b0;
    tick();
    bus.exm_regwrite = 1'b1; bus.exm_rd = 5'd0; bus.exm_result = 32'hFF;
    #1;
    check_eq("x0_store_data", bus.ex_store_data, 32'd0);
    check_eq("x0_op2", bus.op2, 32'd0);

    // Stall holds across two cycles of changing decode inputs
    clear_inputs();
    bus.id_valid = 1'b1; bus.id_pc = 32'h100; bus.id_rd = 5'd3; bus.id_regwrite = 1'b1;
    tick();
    bus.stall = 1'b1; bus.id_pc = 32'h200; bus.id_valid = 1'b0; bus.id_rd = 5'd9;
    tick();
    check_eq("stall1_pc", bus.ex_pc, 32'h100);
    check_eq("stall1_rd", DW'(bus.ex_rd), 32'd3);
    bus.id_pc = 32'h300; bus.id_rd = 5'd12;
    tick();
    check_eq("stall2_pc", bus.ex_pc, 32'h100);
    check_eq("stall2_valid", DW'(bus.ex_valid), 32'd1);

    // Flush wins over stall
    bus.stall = 1'b1; bus.flush = 1'b1; bus.id_valid = 1'b1; bus.id_memwrite = 1'b1;
    tick();
    check_eq("flush_stall_valid", DW'(bus.ex_valid), 32'd0);
    check_eq("flush_stall_memwrite", DW'(bus.ex_memwrite), 32'd0);

    // Load-use detection
`ifdef LOAD_USE_DETECT_EN
    exp_lu = 1'b1;
`else
    exp_lu = 1'b0;
`endif
    clear_inputs();
    bus.id_valid = 1'b1; bus.id_memread = 1'b1; bus.id_rd = 5'd6; bus.id_regwrite = 1'b1;
    tick();
    bus.id_rs2 = 5'd6; bus.id_rs1 = 5'd1;
    #1;
    check_eq("loaduse_hit", DW'(bus.stall_req), DW'(exp_lu));
    bus.id_rd = 5'd0;
    tick();
    bus.id_rs2 = 5'd0; bus.id_rs1 = 5'd0;
    #1;
    check_eq("loaduse_x0", DW'(bus.stall_req), 32'd0);

    // Randomized traffic
    repeat (400) begin
      @(negedge clk);
      random_inputs();
      #1;
      check_outputs("pre_");
      tick();
      random_fwd();
      #1;
      check_outputs("mid_");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
